// File: rtl/arith_pkg.sv
// Shared types and constants for the registered add/sub/inc/dec/multiply unit.
package arith_pkg;

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_INC  = 3'b001,
      OP_ADD  = 3'b010,
      OP_ADDC = 3'b011,
      OP_SUBB = 3'b100,
      OP_SUB  = 3'b101,
      OP_DEC  = 3'b110,
      OP_MUL  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Largest positive / most negative two's-complement value of width w (w <= 64).
   function automatic logic [63:0] sat_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/adder_n.sv
// WIDTH-bit ripple adder with carry in/out, shared by the ALU ops and the multiply accumulate.
module adder_n #(
   parameter int WIDTH = 8
) (
   input  logic             carry_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/arith_unit_seq.sv
// Registered add/sub/inc/dec unit with a multi-cycle shift-add multiply and valid/ready ports.
// Define ARITH_SAT_EN to saturate ops 010..101 on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | accepting operands; single-cycle ops complete here
// MUL   | WIDTH shift-add steps, then one cycle to load the product
// HOLD  | product valid, waiting for out_ready
module arith_unit_seq
   import arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
`ifdef ARITH_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
   logic             out_valid_q, out_valid_d;

   op_e              op_s;
   logic             accept;
   logic [WIDTH-1:0] add_a, add_b, sum;
   logic             add_cin, add_cout;
   logic             alu_v;
   logic [WIDTH-1:0] alu_res;

   assign op_s     = op_e'(op);
   assign in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   // During MUL the adder belongs to the accumulate step; otherwise it serves the ALU op.
   always_comb begin
      add_a   = a;
      add_b   = '0;
      add_cin = op[0];
      if (state_q == MUL) begin
         add_a   = acc_hi_q;
         add_b   = acc_lo_q[0] ? mcand_q : '0;
         add_cin = 1'b0;
      end else begin
         case (op_s)
            OP_ADD, OP_ADDC: add_b = b;
            OP_SUBB, OP_SUB: add_b = ~b;
            OP_DEC:          add_b = '1;
            default:         add_b = '0;
         endcase
      end
   end

   adder_n #(.WIDTH(WIDTH)) u_adder (
      .carry_in  (add_cin),
      .a         (add_a),
      .b         (add_b),
      .sum       (sum),
      .carry_out (add_cout)
   );

   assign alu_v = (add_a[WIDTH-1] & add_b[WIDTH-1] & ~sum[WIDTH-1]) |
                  (~add_a[WIDTH-1] & ~add_b[WIDTH-1] & sum[WIDTH-1]);

   always_comb begin
      alu_res = sum;
`ifdef ARITH_SAT_EN
      if (alu_v && (op_s inside {OP_ADD, OP_ADDC, OP_SUBB, OP_SUB}))
         alu_res = sum[WIDTH-1] ? SAT_POS : SAT_NEG;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && op_s == OP_MUL) state_d = MUL;
         MUL:     if (cnt_q == CNT_LAST) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      res_d       = res_q;
      res_hi_d    = res_hi_q;
      c_d         = c_q;
      v_d         = v_q;
      z_d         = z_q;
      n_d         = n_q;
      out_valid_d = out_valid_q & ~out_ready;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op_s == OP_MUL) begin
                  mcand_d  = a;
                  acc_lo_d = b;
                  acc_hi_d = '0;
                  cnt_d    = '0;
               end else begin
                  res_d       = alu_res;
                  res_hi_d    = '0;
                  c_d         = add_cout;
                  v_d         = alu_v;
                  z_d         = ~|alu_res;
                  n_d         = alu_res[WIDTH-1];
                  out_valid_d = 1'b1;
               end
            end
         end
         MUL: begin
            if (cnt_q == CNT_LAST) begin
               res_d       = acc_lo_q;
               res_hi_d    = acc_hi_q;
               c_d         = |acc_hi_q;
               v_d         = 1'b0;
               z_d         = ~|{acc_hi_q, acc_lo_q};
               n_d         = 1'b0;
               out_valid_d = 1'b1;
            end else begin
               // Shift the partial sum (with its carry) right; the multiplier drains out of acc_lo.
               acc_hi_d = {add_cout, sum[WIDTH-1:1]};
               acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mcand_q     <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         res_q       <= '0;
         res_hi_q    <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         res_q       <= res_d;
         res_hi_q    <= res_hi_d;
         c_q         <= c_d;
         v_q         <= v_d;
         z_q         <= z_d;
         n_q         <= n_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign result_hi = res_hi_q;
   assign flag_c    = c_q;
   assign flag_v    = v_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed bench for arith_unit_seq at WIDTH=8: vector table plus multiply/handshake/reset sequences.
module tb_arith_unit_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result, result_hi;
   logic       flag_c, flag_v, flag_z, flag_n;
   logic [3:0] flags;

   int n_cmp = 0;
   int n_err = 0;

   assign flags = {flag_c, flag_v, flag_z, flag_n};

   always #5 clk = ~clk;

   arith_unit_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_z    (flag_z),
      .flag_n    (flag_n)
   );

   // flags packed as {C,V,Z,N}
   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] f;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb,
                          input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                          input logic [3:0] exp_f);
      int   lat;
      logic rdy_bad;
      logic [7:0] hold_lo;
      @(negedge clk);
      op = 3'b111; a = ma; b = mb; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      rdy_bad = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (in_ready) rdy_bad = 1'b1;
      end
      check("mul_latency", lat, 9);
      hold_lo = result;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (in_ready || !out_valid || result !== hold_lo) rdy_bad = 1'b1;
      end
      check("mul_ready_low_and_hold", {31'd0, rdy_bad}, 0);
      check("mul_lo", result, exp_lo);
      check("mul_hi", result_hi, exp_hi);
      check("mul_flags", flags, exp_f);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("mul_drain_valid", out_valid, 0);
      check("mul_drain_ready", in_ready, 1);
   endtask

   initial begin
      vecs[0]  = '{3'b101, 8'h50, 8'h30, 8'h20, 4'b1000};
`ifdef ARITH_SAT_EN
      vecs[1]  = '{3'b010, 8'h70, 8'h20, 8'h7F, 4'b0100};
`else
      vecs[1]  = '{3'b010, 8'h70, 8'h20, 8'h90, 4'b0101};
`endif
      vecs[2]  = '{3'b001, 8'hFF, 8'h00, 8'h00, 4'b1010};
      vecs[3]  = '{3'b110, 8'h00, 8'h00, 8'hFF, 4'b0001};
      vecs[4]  = '{3'b000, 8'hA5, 8'h3C, 8'hA5, 4'b0001};
      vecs[5]  = '{3'b011, 8'h01, 8'h01, 8'h03, 4'b0000};
      vecs[6]  = '{3'b100, 8'h05, 8'h03, 8'h01, 4'b1000};
      vecs[7]  = '{3'b101, 8'h03, 8'h05, 8'hFE, 4'b0001};
`ifdef ARITH_SAT_EN
      vecs[8]  = '{3'b101, 8'h80, 8'h01, 8'h80, 4'b1101};
      vecs[9]  = '{3'b010, 8'h80, 8'h80, 8'h80, 4'b1101};
      vecs[10] = '{3'b011, 8'h7F, 8'h00, 8'h7F, 4'b0100};
`else
      vecs[8]  = '{3'b101, 8'h80, 8'h01, 8'h7F, 4'b1100};
      vecs[9]  = '{3'b010, 8'h80, 8'h80, 8'h00, 4'b1110};
      vecs[10] = '{3'b011, 8'h7F, 8'h00, 8'h80, 4'b0101};
`endif
      vecs[11] = '{3'b110, 8'h01, 8'h00, 8'h00, 4'b1010};
      vecs[12] = '{3'b001, 8'h7F, 8'h00, 8'h80, 4'b0101};

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_result", {result_hi, result}, 0);
      check("rst_flags", flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Single-op vectors with an idle cycle between them
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
         check("vec_in_ready", in_ready, 1);
         @(negedge clk);
         in_valid = 1'b0;
         check("vec_out_valid", out_valid, 1);
         check($sformatf("vec%0d_result", i), result, vecs[i].res);
         check($sformatf("vec%0d_result_hi", i), result_hi, 0);
         check($sformatf("vec%0d_flags", i), flags, vecs[i].f);
      end

      // Back-to-back: one result per cycle, then a 3-cycle stall
      @(negedge clk);
      op = vecs[0].op; a = vecs[0].a; b = vecs[0].b; in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("b2b%0d_valid", i - 1), out_valid, 1);
         check($sformatf("b2b%0d_result", i - 1), result, vecs[i-1].res);
         check($sformatf("b2b%0d_flags", i - 1), flags, vecs[i-1].f);
         if (i < 4) begin
            check("b2b_in_ready", in_ready, 1);
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
         end else begin
            in_valid = 1'b0;
            out_ready = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
         check("stall_result", result, vecs[3].res);
         check("stall_flags", flags, vecs[3].f);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_valid", out_valid, 0);

      // Multiply
      run_mul(8'hFF, 8'hFF, 8'hFE, 8'h01, 4'b1000);
      run_mul(8'h0D, 8'h0B, 8'h00, 8'h8F, 4'b0000);
      run_mul(8'h00, 8'h37, 8'h00, 8'h00, 4'b0010);

      // Reset during the 4th MUL cycle aborts the multiply
      @(negedge clk);
      op = 3'b111; a = 8'h03; b = 8'h05; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midmul_rst_valid", out_valid, 0);
      check("midmul_rst_ready", in_ready, 0);
      check("midmul_rst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         check("midmul_aborted", {31'd0, seen}, 0);
      end
      check("post_rst_ready", in_ready, 1);
      op = 3'b011; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("post_rst_valid", out_valid, 1);
      check("post_rst_result", result, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational add/sub/inc/dec unit.
- Keeps the same 3-bit operation encoding {S,Cin} for the single-cycle ops and recodes 3'b111 as a multi-cycle unsigned shift-add multiply.
- Operands enter and results leave through valid/ready handshakes, so the block sits between the register-file read stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept operands this cycle
- op  input  3  {S[1:0],Cin} operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  result, or low half of the product
- result_hi  output  WIDTH  high half of the product; 0 for non-multiply ops
- flag_c  output  1  carry out (subtract: 1 = no borrow)
- flag_v  output  1  signed overflow
- flag_z  output  1  zero flag: result==0; for multiply, the full 2·WIDTH product==0
- flag_n  output  1  result MSB; 0 for multiply

Behaviour:
- Reset: all outputs and state registers go to 0, state=IDLE, and in_ready=0 while rst_n is low.
  - Reset in mid-operation aborts any multiply and drops any pending result without emitting it.
- Op encoding (sum = adderA + adderB + cin, WIDTH bits; flag_c is the carry out):
  - 000: A+0+0 (transfer)
  - 001: A+0+1 (increment)
  - 010: A+B+0
  - 011: A+B+1
  - 100: A+~B+0 (A−B−1)
  - 101: A+~B+1 (A−B)
  - 110: A+all-ones+0 (decrement)
  - 111: unsigned multiply A×B
- flag_v = (adderA[W-1] & adderB[W-1] & ~sum[W-1]) | (~adderA[W-1] & ~adderB[W-1] & sum[W-1]).
  - For multiply: flag_v=0 and flag_c = |result_hi.
- State machine: IDLE, MUL, HOLD.
  - in_ready = (state==IDLE) & (~out_valid | out_ready).
  - The transfer is accepted when in_valid & in_ready.
  - IDLE, non-multiply op accepted: result and flags register at the next edge, out_valid=1 (latency 1). State stays IDLE, so back-to-back accepts give one result per cycle while out_ready=1.
  - IDLE, op 111 accepted: latch a and b, clear the accumulator, counter=0, go to MUL.
  - MUL: one shift-add step per cycle. After WIDTH steps, load result/result_hi/flags, set out_valid=1 and go to HOLD.
    - First out_valid is exactly WIDTH+1 cycles after the accept edge.
  - HOLD: wait for out_ready, then go to IDLE. in_ready stays 0 during MUL and HOLD.
- Output hold: out_valid & ~out_ready holds result, result_hi and all flags stable, and in_ready=0.
  - A result with out_valid=1 and out_ready=1 in IDLE can be replaced by a new accept in the same cycle, with no bubble.
  - out_valid drops when out_ready=1 and no new result is being loaded.
- Wrap-around: when op 001 sees all-ones, or op 110 sees 0, the result wraps and flag_c follows the carry rule.
  - Example (WIDTH=8): A=8'h00 with op 110 gives FF, C=0.
- flag_z and flag_n are computed from the final registered result value (after saturation, if enabled).

Optional Feature:
- Macro: ARITH_SAT_EN.
- When defined, ops 010–101 saturate whenever flag_v=1:
  - positive overflow gives 0111…1;
  - negative overflow gives 1000…0.
  - flag_v still reports the overflow.
- When undefined, results wrap modulo 2^WIDTH.
- Multiply and ops 000/001/110 are unaffected in both builds.

Decomposition:
- Package arith_pkg holds:
  - the op_e enum: OP_PASS, OP_INC, OP_ADD, OP_ADDC, OP_SUBB, OP_SUB, OP_DEC, OP_MUL;
  - the state_e enum: IDLE, MUL, HOLD;
  - the saturation constant functions.
- One sub-module, adder_n (parameter WIDTH; ports carry_in, a, b, sum, carry_out), is shared by the ALU ops and by the multiply accumulate step.

Test Plan (WIDTH=8):
- Op 101, A=8'h50, B=8'h30, out_ready=1 → one cycle later result=8'h20, C=1, V=0, Z=0, N=0.
- Op 010, A=8'h70, B=8'h20 → result=8'h90, V=1, N=1 (wrap build); with ARITH_SAT_EN → result=8'h7F, V=1.
- Op 111, A=8'hFF, B=8'hFF → out_valid exactly 9 cycles after accept, result_hi=8'hFE, result=8'h01, C=1; in_ready=0 throughout.
- Back-to-back: 4 ops with in_valid and out_ready held high → 4 results on consecutive cycles in order; then out_ready=0 for 3 cycles → outputs frozen and in_ready=0.
- Boundaries: op 001 with A=8'hFF → 8'h00, C=1, Z=1; op 110 with A=8'h00 → 8'hFF, C=0.
- Assert rst_n=0 in the 4th MUL cycle → out_valid=0 and in_ready=0 immediately; after release a new op 011 with A=1, B=1 gives result=8'h03.
